// File: rtl/lp_dmem_pm.sv
// -----------------------------------------------------------------------------
// lp_dmem_pm -- dual-port banked data memory with built-in power management
//
// Stores NUM_BANK independent DW-bit words per address (depth 2^AW) and serves
// two request/ready ports. Writes are masked per bank. Read data is registered,
// with one cycle of latency. An idle-driven state machine moves the array from
// ACTIVE into light sleep (LS) and deep sleep (DS). The sd input forces
// shutdown (SD). The WAKE state counts out the array's wake-up latency before
// requests are accepted again.
//
// Optional feature macro: LP_DMEM_PARITY_EN
//   defined   : one even-parity bit per bank word. Any read of a valid word
//               that sees a parity mismatch on any bank sets the sticky
//               par_err output.
//   undefined : no parity storage, and par_err is tied low.
//
// Ports
//   clk              in   clock; all state changes on the rising edge
//   rst              in   synchronous active-high reset, overrides everything
//   sd               in   shutdown request (level)
//   pN_req           in   request on port N (N = 1, 2)
//   pN_we            in   1 = write, 0 = read
//   pN_addr          in   word address
//   pN_ben           in   per-bank write enable (ignored for reads)
//   pN_wdata         in   write data; bank i at [DW*i +: DW]
//   pN_ready         out  request accepted this cycle when pN_req & pN_ready
//   pN_rvalid        out  read data valid (one cycle after acceptance)
//   pN_rdata         out  read data; held until the next accepted read
//   pwr_state        out  0 ACTIVE, 1 LS, 2 DS, 3 SD, 4 WAKE
//   par_err          out  sticky parity error (cleared only by rst)
// -----------------------------------------------------------------------------
module lp_dmem_pm #(
    parameter int NUM_BANK = 48,
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LS_IDLE  = 16,
    parameter int DS_IDLE  = 256,
    parameter int LS_WAKE  = 1,
    parameter int DS_WAKE  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sd,

    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [AW-1:0]          p1_addr,
    input  logic [NUM_BANK-1:0]    p1_ben,
    input  logic [DW*NUM_BANK-1:0] p1_wdata,
    output logic                   p1_ready,
    output logic                   p1_rvalid,
    output logic [DW*NUM_BANK-1:0] p1_rdata,

    input  logic                   p2_req,
    input  logic                   p2_we,
    input  logic [AW-1:0]          p2_addr,
    input  logic [NUM_BANK-1:0]    p2_ben,
    input  logic [DW*NUM_BANK-1:0] p2_wdata,
    output logic                   p2_ready,
    output logic                   p2_rvalid,
    output logic [DW*NUM_BANK-1:0] p2_rdata,

    output logic [2:0]             pwr_state,
    output logic                   par_err
);

    localparam int DEPTH    = 1 << AW;
    localparam int WW       = DW * NUM_BANK;
    localparam int IDLE_W   = $clog2(DS_IDLE + 1);
    localparam int WAKE_MAX = (LS_WAKE > DS_WAKE) ? LS_WAKE : DS_WAKE;
    localparam int WAKE_W   = $clog2(WAKE_MAX + 1);

    localparam logic [IDLE_W-1:0] C_LS_IDLE = IDLE_W'(LS_IDLE);
    localparam logic [IDLE_W-1:0] C_DS_IDLE = IDLE_W'(DS_IDLE);
    localparam logic [WAKE_W-1:0] C_LS_WAKE = WAKE_W'(LS_WAKE);
    localparam logic [WAKE_W-1:0] C_DS_WAKE = WAKE_W'(DS_WAKE);

    typedef enum logic [2:0] {
        ST_ACTIVE = 3'd0,
        ST_LS     = 3'd1,
        ST_DS     = 3'd2,
        ST_SD     = 3'd3,
        ST_WAKE   = 3'd4
    } pwr_state_t;

    // -------------------------------------------------------------------------
    // Power-management state machine
    // -------------------------------------------------------------------------
    pwr_state_t        r_state;
    pwr_state_t        w_state_nxt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [IDLE_W-1:0] w_idle_nxt;
    logic [IDLE_W-1:0] w_idle_inc;
    logic [WAKE_W-1:0] r_wake_cnt;
    logic [WAKE_W-1:0] w_wake_nxt;
    logic              w_any_req;

    assign w_any_req  = p1_req || p2_req;
    // The idle counter saturates at DS_IDLE.
    assign w_idle_inc = (r_idle_cnt == C_DS_IDLE) ? r_idle_cnt
                                                  : r_idle_cnt + IDLE_W'(1);

    // NOTE: every variable gets a default before the case statement. A path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle_cnt;
        w_wake_nxt  = r_wake_cnt;

        case (r_state)
            ST_ACTIVE: begin
                if (w_any_req) begin
                    w_idle_nxt = '0;
                end else begin
                    w_idle_nxt = w_idle_inc;
                    // The state changes on the same edge the counter reaches
                    // the threshold.
                    if (w_idle_inc == C_LS_IDLE) begin
                        w_state_nxt = ST_LS;
                    end
                end
            end
            ST_LS: begin
                if (w_any_req) begin
                    w_state_nxt = ST_WAKE;
                    w_wake_nxt  = C_LS_WAKE;
                    w_idle_nxt  = '0;
                end else begin
                    w_idle_nxt = w_idle_inc;
                    if (w_idle_inc == C_DS_IDLE) begin
                        w_state_nxt = ST_DS;
                    end
                end
            end
            ST_DS: begin
                if (w_any_req) begin
                    w_state_nxt = ST_WAKE;
                    w_wake_nxt  = C_DS_WAKE;
                    w_idle_nxt  = '0;
                end
            end
            ST_SD: begin
                // sd has fallen; the sd override below catches the held case.
                w_state_nxt = ST_WAKE;
                w_wake_nxt  = C_DS_WAKE;
                w_idle_nxt  = '0;
            end
            ST_WAKE: begin
                w_idle_nxt = '0;
                // The loaded count equals the number of cycles spent in WAKE.
                if (r_wake_cnt <= WAKE_W'(1)) begin
                    w_state_nxt = ST_ACTIVE;
                    w_wake_nxt  = '0;
                end else begin
                    w_wake_nxt = r_wake_cnt - WAKE_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
                w_idle_nxt  = '0;
                w_wake_nxt  = '0;
            end
        endcase

        if (sd) begin
            w_state_nxt = ST_SD;
            w_idle_nxt  = '0;
            w_wake_nxt  = '0;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments. Every flop
    // then samples pre-edge values, whatever order the processes run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ACTIVE;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_wake_cnt <= w_wake_nxt;
        end
    end

    assign pwr_state = r_state;

    // -------------------------------------------------------------------------
    // Request acceptance
    // -------------------------------------------------------------------------
    logic w_p1_acc, w_p1_wr, w_p1_rd;
    logic w_p2_acc, w_p2_wr, w_p2_rd;
    logic w_same_addr;

    assign p1_ready    = (r_state == ST_ACTIVE) && !sd;
    assign p2_ready    = (r_state == ST_ACTIVE) && !sd;
    assign w_p1_acc    = p1_req && p1_ready && !rst;
    assign w_p2_acc    = p2_req && p2_ready && !rst;
    assign w_p1_wr     = w_p1_acc && p1_we;
    assign w_p1_rd     = w_p1_acc && !p1_we;
    assign w_p2_wr     = w_p2_acc && p2_we;
    assign w_p2_rd     = w_p2_acc && !p2_we;
    assign w_same_addr = (p1_addr == p2_addr);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DW-1:0]       r_mem [DEPTH][NUM_BANK];
    logic [DEPTH-1:0]    r_valid;
    logic [NUM_BANK-1:0] w_p1_bwe, w_p2_bwe;
    logic [WW-1:0]       w_p1_bdat, w_p2_bdat;

    // The first write to an invalid address also zero-fills the banks that no
    // port enables. A word that becomes valid then never exposes stale
    // contents, and its stored parity stays consistent. Port 1's zero-fill
    // yields to a real port-2 write of the same bank.
    always_comb begin
        w_p1_bwe  = '0;
        w_p2_bwe  = '0;
        w_p1_bdat = '0;
        w_p2_bdat = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            w_p2_bwe[b] = w_p2_wr && (p2_ben[b] || !r_valid[p2_addr]);
            w_p1_bwe[b] = w_p1_wr &&
                          (p1_ben[b] ||
                           (!r_valid[p1_addr] &&
                            !(w_p2_wr && w_same_addr && p2_ben[b])));
            w_p1_bdat[b*DW +: DW] = p1_ben[b] ? p1_wdata[b*DW +: DW] : '0;
            w_p2_bdat[b*DW +: DW] = p2_ben[b] ? p2_wdata[b*DW +: DW] : '0;
        end
    end

`ifdef LP_DMEM_PARITY_EN
    logic [NUM_BANK-1:0] r_par [DEPTH];
`endif

    // NOTE: the data array has no reset. Validity lives in r_valid, which is
    // reset, so the RAM contents never need clearing.
    // Port 2 is written first, so port 1's later assignment wins a same-bank,
    // same-address collision.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANK; b++) begin
            if (w_p2_bwe[b]) begin
                r_mem[p2_addr][b] <= w_p2_bdat[b*DW +: DW];
`ifdef LP_DMEM_PARITY_EN
                r_par[p2_addr][b] <= ^w_p2_bdat[b*DW +: DW];
`endif
            end
            if (w_p1_bwe[b]) begin
                r_mem[p1_addr][b] <= w_p1_bdat[b*DW +: DW];
`ifdef LP_DMEM_PARITY_EN
                r_par[p1_addr][b] <= ^w_p1_bdat[b*DW +: DW];
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read path
    // -------------------------------------------------------------------------
    logic [WW-1:0] w_p1_word, w_p2_word;
    logic          r_p1_rvalid, r_p2_rvalid;
    logic [WW-1:0] r_p1_rdata, r_p2_rdata;

    always_comb begin
        w_p1_word = '0;
        w_p2_word = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            w_p1_word[b*DW +: DW] = r_mem[p1_addr][b];
            w_p2_word[b*DW +: DW] = r_mem[p2_addr][b];
        end
    end

    // Reads sample the array before this edge's writes land. A same-cycle
    // write on the other port is therefore invisible to the read. sd drops
    // ready, so nothing is accepted while the contents are being invalidated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_p1_rvalid <= 1'b0;
            r_p2_rvalid <= 1'b0;
            r_p1_rdata  <= '0;
            r_p2_rdata  <= '0;
        end else begin
            if (sd) begin
                r_valid <= '0;
            end else begin
                if (w_p1_wr) r_valid[p1_addr] <= 1'b1;
                if (w_p2_wr) r_valid[p2_addr] <= 1'b1;
            end
            r_p1_rvalid <= w_p1_rd;
            r_p2_rvalid <= w_p2_rd;
            if (w_p1_rd) r_p1_rdata <= r_valid[p1_addr] ? w_p1_word : '0;
            if (w_p2_rd) r_p2_rdata <= r_valid[p2_addr] ? w_p2_word : '0;
        end
    end

    assign p1_rvalid = r_p1_rvalid;
    assign p2_rvalid = r_p2_rvalid;
    assign p1_rdata  = r_p1_rdata;
    assign p2_rdata  = r_p2_rdata;

    // -------------------------------------------------------------------------
    // Parity checking
    // -------------------------------------------------------------------------
`ifdef LP_DMEM_PARITY_EN
    logic w_p1_perr, w_p2_perr;
    logic r_par_err;

    always_comb begin
        w_p1_perr = 1'b0;
        w_p2_perr = 1'b0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if ((^r_mem[p1_addr][b]) != r_par[p1_addr][b]) w_p1_perr = 1'b1;
            if ((^r_mem[p2_addr][b]) != r_par[p2_addr][b]) w_p2_perr = 1'b1;
        end
        // Only valid words are checked. Invalid words are never returned.
        w_p1_perr = w_p1_perr && w_p1_rd && r_valid[p1_addr];
        w_p2_perr = w_p2_perr && w_p2_rd && r_valid[p2_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_p1_perr || w_p2_perr) begin
            r_par_err <= 1'b1;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

endmodule
